// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble opcode, instruction field positions and
// the IF/ID entry record reused by the stage queues.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] NOP_OPCODE = 7'd50;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 21;
  localparam int RS2_MSB = 20;
  localparam int RS2_LSB = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int OFF_MSB = 15;
  localparam int IMM_MSB = 25;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_next;
  } if_id_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle: the queue takes the slave view, the fetch and
// decode side (or a bench) takes the master view.
interface fetch_decode_queue_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] PC_next;
  logic              IF_Flush;
  logic              out_ready;
  logic              out_valid;
  logic [6:0]        opcode;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       offset;
  logic [25:0]       imm;
  logic [DATA_W-1:0] PC_next_IF;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, instruction, PC_next, IF_Flush, out_ready,
    output in_ready, out_valid, opcode, rs1, rs2, rd, shamt, funct,
           offset, imm, PC_next_IF, count
  );

  modport master (
    output in_valid, instruction, PC_next, IF_Flush, out_ready,
    input  in_ready, out_valid, opcode, rs1, rs2, rd, shamt, funct,
           offset, imm, PC_next_IF, count
  );
endinterface

// File: rtl/if_id_field_split.sv
// Splits a 32-bit instruction word into R/I/J fields; drives the bubble
// pattern (NOP opcode, all other fields zero) when the word is not valid.
module if_id_field_split
  import pipeline_pkg::*;
#(
  parameter logic [6:0] NOP_OP = NOP_OPCODE
) (
  input  logic        i_valid,
  input  logic [31:0] i_word,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_offset,
  output logic [25:0] o_imm
);

  // field slicing with bubble substitution
  always_comb begin
    o_opcode = NOP_OP;
    o_rs1    = 5'd0;
    o_rs2    = 5'd0;
    o_rd     = 5'd0;
    o_shamt  = 5'd0;
    o_funct  = 6'd0;
    o_offset = 16'd0;
    o_imm    = 26'd0;
    if (i_valid) begin
      o_opcode = {1'b0, i_word[OPC_MSB:OPC_LSB]};
      o_rs1    = i_word[RS1_MSB:RS1_LSB];
      o_rs2    = i_word[RS2_MSB:RS2_LSB];
      o_rd     = i_word[RD_MSB:RD_LSB];
      o_shamt  = i_word[SH_MSB:SH_LSB];
      o_funct  = i_word[FN_MSB:FN_LSB];
      o_offset = i_word[OFF_MSB:0];
      o_imm    = i_word[IMM_MSB:0];
    end else begin
      o_opcode = NOP_OP;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry IF/ID FIFO: fetch pushes {instruction, PC_next}, decode pops the
// head with fields pre-split; flush empties the queue and injects bubbles.
module fetch_decode_queue
  import pipeline_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         DEPTH      = 4,
  parameter logic [6:0] NOP_OPCODE = pipeline_pkg::NOP_OPCODE,
  parameter int         CNT_W      = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  fetch_decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  if_id_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  if_id_entry_t     w_head;
  logic [DATA_W-1:0] w_pc_out;

  // handshake flags come only from the registered count
  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != {CNT_W{1'b0}});
  assign w_push      = bus.in_valid && w_in_ready && !bus.IF_Flush;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.IF_Flush;
  assign w_head      = r_mem[r_rd_ptr];

  // pointer and occupancy state; reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (bus.IF_Flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // entry storage; stale slots are never visible because count gates out_valid
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= '{instruction: bus.instruction, pc_next: bus.PC_next};
    end
  end

  always_comb begin
    w_pc_out = {DATA_W{1'b0}};
    if (w_out_valid) begin
      w_pc_out = w_head.pc_next;
    end else begin
      w_pc_out = {DATA_W{1'b0}};
    end
  end

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_offset;
  logic [25:0] w_imm;

  if_id_field_split #(.NOP_OP(NOP_OPCODE)) u_split (
    .i_valid  (w_out_valid),
    .i_word   (w_head.instruction),
    .o_opcode (w_opcode),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd),
    .o_shamt  (w_shamt),
    .o_funct  (w_funct),
    .o_offset (w_offset),
    .o_imm    (w_imm)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.count      = r_count;
  assign bus.PC_next_IF = w_pc_out;
  assign bus.opcode     = w_opcode;
  assign bus.rs1        = w_rs1;
  assign bus.rs2        = w_rs2;
  assign bus.rd         = w_rd;
  assign bus.shamt      = w_shamt;
  assign bus.funct      = w_funct;
  assign bus.offset     = w_offset;
  assign bus.imm        = w_imm;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed table-driven bench for fetch_decode_queue (DEPTH=4) plus a few
// hand-written corner sequences.
module tb_fetch_decode_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_decode_queue_if #(.DATA_W(32), .CNT_W(3)) bus ();

  fetch_decode_queue #(.DATA_W(32), .DEPTH(4), .NOP_OPCODE(7'd50), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [2:0]  ec;
    logic [6:0]  eop;
    logic [4:0]  ers1;
    logic [4:0]  ers2;
    logic [15:0] eoff;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic fl, input logic ordy, input logic ev, input logic er,
                     input logic [2:0] ec, input logic [6:0] eop, input logic [4:0] ers1,
                     input logic [4:0] ers2, input logic [15:0] eoff, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.iv = iv; v.ins = ins; v.pc = pc; v.fl = fl; v.ordy = ordy;
    v.ev = ev; v.er = er; v.ec = ec; v.eop = eop; v.ers1 = ers1; v.ers2 = ers2;
    v.eoff = eoff; v.epc = epc;
    vecs.push_back(v);
  endtask

  // expected empty queue: bubble fields
  task automatic add_bub(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
    add(r, iv, ins, pc, fl, ordy, 1'b0, 1'b1, 3'd0, 7'd50, 5'd0, 5'd0, 16'd0, 32'd0);
  endtask

  // P-series words: opcode k, rs1 k, rs2 k+1, offset 3k
  function automatic logic [31:0] p_ins(input int k);
    logic [5:0]  o = 6'(k);
    logic [4:0]  a = 5'(k);
    logic [4:0]  b = 5'(k + 1);
    logic [15:0] f = 16'(3 * k);
    return {o, a, b, f};
  endfunction

  function automatic logic [31:0] p_pc(input int k);
    return 32'h0000_0100 + 32'(4 * (k - 1));
  endfunction

  task automatic add_p(input logic iv, input int push_k, input logic ordy, input logic [2:0] ec,
                       input logic er, input int head_k);
    add(1'b0, iv, p_ins(push_k), p_pc(push_k), 1'b0, ordy, 1'b1, er, ec,
        7'(head_k), 5'(head_k), 5'(head_k + 1), 16'(3 * head_k), p_pc(head_k));
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    rst = r; bus.in_valid = iv; bus.instruction = ins; bus.PC_next = pc;
    bus.IF_Flush = fl; bus.out_ready = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // reset and idle
    add_bub(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    add_bub(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    // single push of lw-like word, then pop
    add(1'b0, 1'b1, 32'h8C22_0004, 32'h0000_0104, 1'b0, 1'b0,
        1'b1, 1'b1, 3'd1, 7'h23, 5'd1, 5'd2, 16'h0004, 32'h0000_0104);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    // fill to full with opcodes 8..11, PCs 4..0x10; fifth push refused
    add(1'b0, 1'b1, 32'h2000_0000, 32'h4,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 7'd8, 5'd0, 5'd0, 16'd0, 32'h4);
    add(1'b0, 1'b1, 32'h2400_0000, 32'h8,  1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 7'd8, 5'd0, 5'd0, 16'd0, 32'h4);
    add(1'b0, 1'b1, 32'h2800_0000, 32'hC,  1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 7'd8, 5'd0, 5'd0, 16'd0, 32'h4);
    add(1'b0, 1'b1, 32'h2C00_0000, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 7'd8, 5'd0, 5'd0, 16'd0, 32'h4);
    add(1'b0, 1'b1, 32'hFC00_0000, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 7'd8, 5'd0, 5'd0, 16'd0, 32'h4);
    // drain: full blocks the offered entry even while popping
    add(1'b0, 1'b1, 32'hFC00_0000, 32'h99, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 7'd9,  5'd0, 5'd0, 16'd0, 32'h8);
    add(1'b0, 1'b0, 32'd0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd10, 5'd0, 5'd0, 16'd0, 32'hC);
    add(1'b0, 1'b0, 32'd0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 7'd11, 5'd0, 5'd0, 16'd0, 32'h10);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    // count=2, then 8 push+pop cycles wrap the pointers twice
    add_p(1'b1, 1, 1'b0, 3'd1, 1'b1, 1);
    add_p(1'b1, 2, 1'b0, 3'd2, 1'b1, 1);
    for (int n = 1; n <= 8; n++) add_p(1'b1, n + 2, 1'b1, 3'd2, 1'b1, n + 1);
    add_p(1'b1, 11, 1'b0, 3'd3, 1'b1, 9);
    // flush with concurrent push and pop, then a second flush
    add_bub(1'b0, 1'b1, 32'hFC00_FFFF, 32'h0000_DEAD, 1'b1, 1'b1);
    add_bub(1'b0, 1'b1, 32'hFC00_FFFF, 32'h0000_DEAD, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h1443_0007, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 7'd5, 5'd2, 5'd3, 16'd7, 32'h200);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    // reset mid-stream with push and pop requested
    add(1'b0, 1'b1, 32'h0C00_0000, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 7'd3, 5'd0, 5'd0, 16'd0, 32'h300);
    add(1'b0, 1'b1, 32'h1000_0000, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 7'd3, 5'd0, 5'd0, 16'd0, 32'h300);
    add_bub(1'b1, 1'b1, 32'h1800_0000, 32'h308, 1'b0, 1'b1);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h1C00_0000, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 7'd7, 5'd0, 5'd0, 16'd0, 32'h400);
    add_bub(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk("out_valid",  i, 32'(bus.out_valid),  32'(vecs[i].ev));
      chk("in_ready",   i, 32'(bus.in_ready),   32'(vecs[i].er));
      chk("count",      i, 32'(bus.count),      32'(vecs[i].ec));
      chk("opcode",     i, 32'(bus.opcode),     32'(vecs[i].eop));
      chk("rs1",        i, 32'(bus.rs1),        32'(vecs[i].ers1));
      chk("rs2",        i, 32'(bus.rs2),        32'(vecs[i].ers2));
      chk("offset",     i, 32'(bus.offset),     32'(vecs[i].eoff));
      chk("PC_next_IF", i, bus.PC_next_IF,      vecs[i].epc);
    end

    // no combinational path: offering an entry mid-cycle changes nothing yet
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1;
    chk("comb_out_valid", 100, 32'(bus.out_valid), 32'd0);
    chk("comb_count",     100, 32'(bus.count),     32'd0);
    chk("comb_in_ready",  100, 32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    chk("ones_opcode", 101, 32'(bus.opcode), 32'h3F);
    chk("ones_rd",     101, 32'(bus.rd),     32'd31);
    chk("ones_shamt",  101, 32'(bus.shamt),  32'd31);
    chk("ones_funct",  101, 32'(bus.funct),  32'd63);
    chk("ones_imm",    101, 32'(bus.imm),    32'h03FF_FFFF);
    chk("ones_pc",     101, bus.PC_next_IF,  32'hFFFF_FFFF);

    // flush: every field back to bubble
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("bub_opcode", 102, 32'(bus.opcode), 32'd50);
    chk("bub_rd",     102, 32'(bus.rd),     32'd0);
    chk("bub_shamt",  102, 32'(bus.shamt),  32'd0);
    chk("bub_funct",  102, 32'(bus.funct),  32'd0);
    chk("bub_imm",    102, 32'(bus.imm),    32'd0);
    chk("bub_count",  102, 32'(bus.count),  32'd0);

    // out_ready on empty queue does not underflow
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("empty_pop_count", 103 + k, 32'(bus.count), 32'd0);
    end

    // push plus out_ready on empty: only the push takes effect
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0421_0000, 32'h500, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("empty_pp_count", 105, 32'(bus.count),     32'd1);
    chk("empty_pp_pc",    105, bus.PC_next_IF,     32'h500);
    chk("empty_pp_rs1",   105, 32'(bus.rs1),       32'd1);

    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
